// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: decode, register file, load-use hazard detect, ID/EX register
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instruction_in,
  input  logic            instruction_valid_in,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_rs1_data,
  output logic [XLEN-1:0] id_ex_rs2_data,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rs1,
  output logic [4:0]      id_ex_rs2,
  output logic [4:0]      id_ex_rd,
  output logic            id_ex_reg_write,
  output logic            id_ex_mem_read,
  output logic            id_ex_mem_write,
  output logic            id_ex_branch,
  output logic            id_ex_alu_src,
  output logic            id_ex_mem_to_reg,
  output logic            id_ex_valid,
  output logic [1:0]      id_ex_alu_op,
  output logic [2:0]      id_ex_funct3,
  output logic            id_ex_funct7b5
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            alu_src;
    logic            mem_to_reg;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
  } id_ex_t;

  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_used;
  logic            rs2_used;
  id_ex_t          dec;
  id_ex_t          ex_next;
  id_ex_t          ex_q;
  logic            load_bubble;

  assign opcode = instruction_in[6:0];
  assign rd     = instruction_in[11:7];
  assign rs1    = instruction_in[19:15];
  assign rs2    = instruction_in[24:20];

  // Register file: x0 is never stored so it always reads back as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Operand read with write-through bypass so a same-cycle writeback is seen immediately
  always_comb begin
    rs1_data = regs[rs1];
    rs2_data = regs[rs2];
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1)) rs1_data = wb_data;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2)) rs2_data = wb_data;
    if (rs1 == 5'd0) rs1_data = '0;
    if (rs2 == 5'd0) rs2_data = '0;
  end

  // Main decoder: controls, immediate and which source registers the instruction reads
  always_comb begin
    dec      = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (opcode)
      OP_R: begin
        dec.valid     = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
      end
      OP_I: begin
        dec.valid     = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = 2'b10;
        dec.imm       = {{(XLEN-12){instruction_in[31]}}, instruction_in[31:20]};
        rs1_used      = 1'b1;
      end
      OP_LD: begin
        dec.valid      = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.imm        = {{(XLEN-12){instruction_in[31]}}, instruction_in[31:20]};
        rs1_used       = 1'b1;
      end
      OP_SD: begin
        dec.valid     = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = {{(XLEN-12){instruction_in[31]}}, instruction_in[31:25], instruction_in[11:7]};
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
      end
      OP_BEQ: begin
        dec.valid  = 1'b1;
        dec.branch = 1'b1;
        dec.alu_op = 2'b01;
        dec.imm    = {{(XLEN-13){instruction_in[31]}}, instruction_in[31], instruction_in[7],
                      instruction_in[30:25], instruction_in[11:8], 1'b0};
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
      end
      default: ;
    endcase
    dec.funct3   = instruction_in[14:12];
    dec.funct7b5 = instruction_in[30];
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = rd;
    dec.pc       = pc_in;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
  end

  // Load-use hazard: the load in EX has not produced data yet, so hold IF/ID one cycle
  assign stall = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & instruction_valid_in & ~flush &
                 (((ex_q.rd == rs1) & rs1_used) | ((ex_q.rd == rs2) & rs2_used));

  assign load_bubble = flush | stall | ~instruction_valid_in | ~dec.valid;

  // Next ID/EX contents: a bubble is all-zero, which also makes stall self-clearing
  always_comb begin
    ex_next = '0;
    if (!load_bubble) ex_next = dec;
  end

  // ID/EX pipeline register, loaded every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_next;
  end

  assign id_ex_valid      = ex_q.valid;
  assign id_ex_reg_write  = ex_q.reg_write;
  assign id_ex_mem_read   = ex_q.mem_read;
  assign id_ex_mem_write  = ex_q.mem_write;
  assign id_ex_branch     = ex_q.branch;
  assign id_ex_alu_src    = ex_q.alu_src;
  assign id_ex_mem_to_reg = ex_q.mem_to_reg;
  assign id_ex_alu_op     = ex_q.alu_op;
  assign id_ex_funct3     = ex_q.funct3;
  assign id_ex_funct7b5   = ex_q.funct7b5;
  assign id_ex_rs1        = ex_q.rs1;
  assign id_ex_rs2        = ex_q.rs2;
  assign id_ex_rd         = ex_q.rd;
  assign id_ex_pc         = ex_q.pc;
  assign id_ex_rs1_data   = ex_q.rs1_data;
  assign id_ex_rs2_data   = ex_q.rs2_data;
  assign id_ex_imm        = ex_q.imm;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - vector table and scoreboard bench for decode_stage
module tb_decode_stage;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    logic        mem_to_reg;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] imm;
  } idex_t;

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        iv;
    logic        fl;
    logic        we;
    logic [4:0]  wrd;
    logic [63:0] wdata;
    logic        exp_stall;
    idex_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] pc_in = '0;
  logic [31:0] instruction_in = '0;
  logic        instruction_valid_in = 1'b0;
  logic        flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [63:0] wb_data = '0;
  logic        stall;
  logic [63:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch;
  logic        id_ex_alu_src, id_ex_mem_to_reg, id_ex_valid, id_ex_funct7b5;
  logic [1:0]  id_ex_alu_op;
  logic [2:0]  id_ex_funct3;

  idex_t act;
  idex_t exp_q[$];
  vec_t  vecs[$];
  int    n_vec = 0;
  int    n_err = 0;

  decode_stage #(.XLEN(64), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instruction_in(instruction_in),
    .instruction_valid_in(instruction_valid_in), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
    .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_mem_write(id_ex_mem_write), .id_ex_branch(id_ex_branch),
    .id_ex_alu_src(id_ex_alu_src), .id_ex_mem_to_reg(id_ex_mem_to_reg),
    .id_ex_valid(id_ex_valid), .id_ex_alu_op(id_ex_alu_op), .id_ex_funct3(id_ex_funct3),
    .id_ex_funct7b5(id_ex_funct7b5)
  );

  always #5 clk = ~clk;

  assign act = {id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch,
                id_ex_alu_src, id_ex_mem_to_reg, id_ex_alu_op, id_ex_funct3, id_ex_funct7b5,
                id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm};

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d,
                                        input logic [6:0] op);
    return {imm, s1, f3, d, op};
  endfunction

  function automatic idex_t ex_base(input logic [63:0] pc, input logic [4:0] s1, input logic [4:0] s2,
                                    input logic [4:0] d, input logic [63:0] d1, input logic [63:0] d2,
                                    input logic [63:0] imm, input logic [2:0] f3, input logic f7b5);
    idex_t e;
    e = '0;
    e.valid = 1'b1;
    e.pc = pc; e.rs1 = s1; e.rs2 = s2; e.rd = d;
    e.rs1_data = d1; e.rs2_data = d2; e.imm = imm;
    e.funct3 = f3; e.funct7b5 = f7b5;
    return e;
  endfunction

  function automatic idex_t ex_r(input idex_t b);
    idex_t e = b;
    e.reg_write = 1'b1; e.alu_op = 2'b10;
    return e;
  endfunction

  function automatic idex_t ex_ialu(input idex_t b);
    idex_t e = b;
    e.reg_write = 1'b1; e.alu_src = 1'b1; e.alu_op = 2'b10;
    return e;
  endfunction

  function automatic idex_t ex_ld(input idex_t b);
    idex_t e = b;
    e.reg_write = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1; e.alu_src = 1'b1;
    return e;
  endfunction

  function automatic idex_t ex_sd(input idex_t b);
    idex_t e = b;
    e.mem_write = 1'b1; e.alu_src = 1'b1;
    return e;
  endfunction

  function automatic idex_t ex_beq(input idex_t b);
    idex_t e = b;
    e.branch = 1'b1; e.alu_op = 2'b01;
    return e;
  endfunction

  function automatic vec_t mkv(input string n, input logic [63:0] pc, input logic [31:0] inst,
                               input logic iv, input logic fl, input logic we, input logic [4:0] wrd,
                               input logic [63:0] wdata, input logic st, input idex_t e);
    vec_t v;
    v.name = n; v.pc = pc; v.inst = inst; v.iv = iv; v.fl = fl;
    v.we = we; v.wrd = wrd; v.wdata = wdata; v.exp_stall = st; v.exp = e;
    return v;
  endfunction

  task automatic chk_stall(input string n, input logic e);
    n_vec++;
    if (stall !== e) begin
      n_err++;
      $display("FAIL %s stall got %b want %b", n, stall, e);
    end
  endtask

  task automatic chk_out(input string n, input idex_t e);
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s id_ex got %h want %h", n, act, e);
    end
  endtask

  task automatic drive(input vec_t v);
    pc_in = v.pc; instruction_in = v.inst; instruction_valid_in = v.iv; flush = v.fl;
    wb_we = v.we; wb_rd = v.wrd; wb_data = v.wdata;
  endtask

  task automatic apply(input vec_t v);
    idex_t e;
    @(negedge clk);
    drive(v);
    #1 chk_stall(v.name, v.exp_stall);
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk_out(v.name, e);
  endtask

  initial begin
    logic [31:0] add6, addi8, add1, sub11, ori12, ld9, use9, ld0, addi12, sd5, sd9, beqp, beqn;
    vec_t        hold;
    add6   = enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd6);
    addi8  = enc_i(12'hFFF, 5'd7, 3'd0, 5'd8, 7'b0010011);
    add1   = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd1);
    sub11  = enc_r(7'h20, 5'd6, 5'd5, 3'd0, 5'd11);
    ori12  = enc_i(12'h0F0, 5'd5, 3'd6, 5'd12, 7'b0010011);
    ld9    = enc_i(12'h000, 5'd1, 3'd3, 5'd9, 7'b0000011);
    use9   = enc_r(7'h00, 5'd2, 5'd9, 3'd0, 5'd10);
    ld0    = enc_i(12'h000, 5'd1, 3'd3, 5'd0, 7'b0000011);
    addi12 = enc_i(12'd9, 5'd5, 3'd0, 5'd12, 7'b0010011);
    sd5    = 32'hFE51BC23;
    sd9    = 32'hFE91BC23;
    beqp   = 32'h00208863;
    beqn   = 32'h80000063;

    vecs.push_back(mkv("wb_x5", 64'h0F0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 64'h1234, 1'b0, '0));
    vecs.push_back(mkv("add_x6", 64'h100, add6, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_r(ex_base(64'h100, 5'd5, 5'd5, 5'd6, 64'h1234, 64'h1234, 64'h0, 3'd0, 1'b0))));
    vecs.push_back(mkv("addi_bypass", 64'h104, addi8, 1'b1, 1'b0, 1'b1, 5'd7, 64'hDEAD, 1'b0,
      ex_ialu(ex_base(64'h104, 5'd7, 5'd31, 5'd8, 64'hDEAD, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b1))));
    vecs.push_back(mkv("wb_x0", 64'h108, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 64'hFFFF, 1'b0, '0));
    vecs.push_back(mkv("add_x0_ops", 64'h10C, add1, 1'b1, 1'b0, 1'b1, 5'd0, 64'hFFFF, 1'b0,
      ex_r(ex_base(64'h10C, 5'd0, 5'd0, 5'd1, 64'h0, 64'h0, 64'h0, 3'd0, 1'b0))));
    vecs.push_back(mkv("sub", 64'h110, sub11, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_r(ex_base(64'h110, 5'd5, 5'd6, 5'd11, 64'h1234, 64'h0, 64'h0, 3'd0, 1'b1))));
    vecs.push_back(mkv("ori", 64'h114, ori12, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_ialu(ex_base(64'h114, 5'd5, 5'd16, 5'd12, 64'h1234, 64'h0, 64'hF0, 3'd6, 1'b0))));
    vecs.push_back(mkv("sd_neg", 64'h118, sd5, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_sd(ex_base(64'h118, 5'd3, 5'd5, 5'd24, 64'h0, 64'h1234, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b1))));
    vecs.push_back(mkv("beq_pos", 64'h200, beqp, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_beq(ex_base(64'h200, 5'd1, 5'd2, 5'd16, 64'h0, 64'h0, 64'h10, 3'd0, 1'b0))));
    vecs.push_back(mkv("beq_neg", 64'h204, beqn, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_beq(ex_base(64'h204, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_F000, 3'd0, 1'b0))));
    vecs.push_back(mkv("bad_opcode", 64'h208, 32'h0000007F, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0, '0));
    vecs.push_back(mkv("flush_add", 64'h20C, add6, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, '0));
    vecs.push_back(mkv("ld_x9", 64'h13C, ld9, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_ld(ex_base(64'h13C, 5'd1, 5'd0, 5'd9, 64'h0, 64'h0, 64'h0, 3'd3, 1'b0))));
    vecs.push_back(mkv("use_stall", 64'h140, use9, 1'b1, 1'b0, 1'b1, 5'd9, 64'h55, 1'b1, '0));
    vecs.push_back(mkv("use_issue", 64'h140, use9, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_r(ex_base(64'h140, 5'd9, 5'd2, 5'd10, 64'h55, 64'h0, 64'h0, 3'd0, 1'b0))));
    vecs.push_back(mkv("ld_x9_b", 64'h144, ld9, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_ld(ex_base(64'h144, 5'd1, 5'd0, 5'd9, 64'h0, 64'h0, 64'h0, 3'd3, 1'b0))));
    vecs.push_back(mkv("use_flush", 64'h148, use9, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, '0));
    vecs.push_back(mkv("ld_x0", 64'h14C, ld0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_ld(ex_base(64'h14C, 5'd1, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 3'd3, 1'b0))));
    vecs.push_back(mkv("use_x0", 64'h150, add1, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_r(ex_base(64'h150, 5'd0, 5'd0, 5'd1, 64'h0, 64'h0, 64'h0, 3'd0, 1'b0))));
    vecs.push_back(mkv("ld_x9_c", 64'h154, ld9, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_ld(ex_base(64'h154, 5'd1, 5'd0, 5'd9, 64'h0, 64'h0, 64'h0, 3'd3, 1'b0))));
    vecs.push_back(mkv("i_rs2_unused", 64'h158, addi12, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_ialu(ex_base(64'h158, 5'd5, 5'd9, 5'd12, 64'h1234, 64'h55, 64'h9, 3'd0, 1'b0))));
    vecs.push_back(mkv("ld_x9_d", 64'h15C, ld9, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_ld(ex_base(64'h15C, 5'd1, 5'd0, 5'd9, 64'h0, 64'h0, 64'h0, 3'd3, 1'b0))));
    vecs.push_back(mkv("sd_stall", 64'h160, sd9, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1, '0));
    vecs.push_back(mkv("sd_issue", 64'h160, sd9, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_sd(ex_base(64'h160, 5'd3, 5'd9, 5'd24, 64'h0, 64'h55, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b1))));

    #2 rst = 1'b1;
    #1 chk_stall("reset_stall", 1'b0);
    chk_out("reset_idex", '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    apply(mkv("ld_x9_rst", 64'h300, ld9, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_ld(ex_base(64'h300, 5'd1, 5'd0, 5'd9, 64'h0, 64'h0, 64'h0, 3'd3, 1'b0))));
    hold = mkv("use_after_rst", 64'h304, use9, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
      ex_r(ex_base(64'h304, 5'd9, 5'd2, 5'd10, 64'h0, 64'h0, 64'h0, 3'd0, 1'b0)));
    @(negedge clk);
    drive(hold);
    #1 chk_stall("pre_rst_stall", 1'b1);
    rst = 1'b1;
    #1 chk_stall("rst_cancels_stall", 1'b0);
    chk_out("rst_clears_idex", '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_stall("post_rst_stall", 1'b0);
    @(posedge clk);
    #1 chk_out(hold.name, hold.exp);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
